eth_tx_sched: RTL and testbench
===============================

// Module: eth_tx_sched
// PURPOSE
//  Schedules and arbitrates use of the UDP TX path (fifo_d -> mac) between two requesters.
//   - Data: ADC frames accumulated in fifo_d.
//   - Reply: command replies raised by the control plane.
//  Counts ADC frames written to fifo_d and launches a data packet once adc_cnt frames are
//  queued, or when the flush timeout expires. Grants are round-robin and use the fs_/fd_
//  four-phase handshake. Sits between cs_cmd-level control and the udp_tx/fifod2mac workers.
// PARAMETERS
//  CNT_W   8   width of frame counter, adc_cnt, tx_len
//  TOUT_W  16  width of flush-timeout counter and tout_cyc
// PORTS
//  sys_clk     in   1       system clock, all logic on rising edge
//  rst_run     in   1       synchronous, active-high reset
//  enable      in   1       level; high while main FSM is in WORK
//  adc_cnt     in   CNT_W   frames per data packet; 0 treated as 1
//  tout_cyc    in   TOUT_W  flush timeout in sys_clk cycles; 0 disables flush
//  frame_wr    in   1       1-cycle pulse: one ADC frame committed to fifo_d
//  fs_reply    in   1       level: reply pending; held until fd_reply
//  fd_reply    out  1       1-cycle pulse: reply transmission finished
//  fs_udp_tx   out  1       level request to TX worker
//  fd_udp_tx   in   1       level done from TX worker
//  tx_sel      out  1       0 = data packet, 1 = reply; stable while fs_udp_tx high
//  tx_len      out  CNT_W   frames in current data packet; 0 for reply
//  frm_num     out  CNT_W   frames queued, not yet granted
//  ovf         out  1       sticky: frame_wr arrived with frm_num at all-ones
//  sos         out  8       state code, for debug
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; frm_num, timer, last_grant = 0.
//  States (sos): IDLE=00, WAIT=01, DATA=02, REPLY=03, DONE=04.
//  Frame counter: +1 on frame_wr in every state except IDLE.
//   - Saturates at all-ones; a frame_wr at saturation sets ovf.
//   - On data grant: frm_num <= frm_num - tx_len + frame_wr, evaluated in the same cycle.
//  Data pending (dreq): frm_num >= max(adc_cnt,1), OR (tout_cyc!=0 AND timer==tout_cyc-1).
//  Timer: counts in WAIT while frm_num!=0; clears on data grant and whenever frm_num==0.
//  IDLE : enable -> WAIT. frame_wr is ignored.
//  WAIT : enable low -> IDLE, clearing frm_num and timer.
//   - dreq only -> DATA; fs_reply only -> REPLY.
//   - Both -> the requester not granted last (last_grant); after reset data wins.
//   - On DATA entry: tx_len <= frm_num, capped at adc_cnt unless the grant is a timeout
//     flush (then the full frm_num). frame_wr in the grant cycle is counted, not sent.
//  DATA/REPLY: fs_udp_tx=1, tx_sel per state.
//   - fd_udp_tx high -> DONE, deasserting fs_udp_tx next cycle.
//   - REPLY->DONE also pulses fd_reply for 1 cycle.
//  DONE : wait fd_udp_tx low -> WAIT, or IDLE if enable is low. tx_len cleared on exit.
//  Latency: dreq/fs_reply seen in WAIT at cycle n -> fs_udp_tx=1 at n+1.
//   - Back-to-back grants need at least one WAIT cycle in between.
//  enable drop mid-transaction: the transaction completes the full handshake, then IDLE.
//  fd_udp_tx already high on entering DATA/REPLY: advances to DONE after 1 cycle (legal).
//  Reset mid-transaction: immediate return to reset values; no fd_reply.
// TESTING
//  1. adc_cnt=4, tout=0; 4 frame_wr pulses -> fs_udp_tx one cycle after 4th,
//     tx_sel=0, tx_len=4; fd handshake -> frm_num=0, back in WAIT.
//  2. adc_cnt=4, tout=100; 2 frames then idle -> grant at timer=99, tx_len=2.
//  3. fs_reply and dreq both pending, repeated 4x -> grants alternate D,R,D,R from reset.
//     fd_reply pulses once per reply.
//  4. frame_wr in the grant cycle with frm_num=5, adc_cnt=4 -> tx_len=4, frm_num=2.
//  5. enable low while in DATA -> handshake completes, then IDLE; frm_num=0;
//     later frame_wr ignored.
//  6. 256 frame_wr with adc_cnt=255 and fd_udp_tx withheld -> frm_num saturates, ovf=1;
//     rst_run mid-DATA -> all outputs 0 next cycle.

Source files
------------

// File: rtl/eth_tx_sched_if.sv
// Handshake bundle between the TX scheduler and the UDP TX worker / reply source.
// The master side is the scheduler; the slave side is the worker plus the control plane.
interface eth_tx_sched_if #(
   parameter int CNT_W = 8
);
   logic             fs_reply;
   logic             fd_reply;
   logic             fs_udp_tx;
   logic             fd_udp_tx;
   logic             tx_sel;
   logic [CNT_W-1:0] tx_len;

   modport master (
      input  fs_reply, fd_udp_tx,
      output fd_reply, fs_udp_tx, tx_sel, tx_len
   );

   modport slave (
      output fs_reply, fd_udp_tx,
      input  fd_reply, fs_udp_tx, tx_sel, tx_len
   );
endinterface

// File: rtl/eth_tx_sched.sv
// Round-robin scheduler for the UDP TX path: ADC data packets versus command replies.
// Data is requested by frame count or by flush timeout; grants use the fs_/fd_ handshake.
module eth_tx_sched #(
   parameter int CNT_W  = 8,
   parameter int TOUT_W = 16
) (
   input  logic                  sys_clk,
   input  logic                  rst_run,
   input  logic                  enable,
   input  logic [CNT_W-1:0]      adc_cnt,
   input  logic [TOUT_W-1:0]     tout_cyc,
   input  logic                  frame_wr,
   eth_tx_sched_if.master        tx,
   output logic [CNT_W-1:0]      frm_num,
   output logic                  ovf,
   output logic [7:0]            sos
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_DATA  = 3'd2,
      S_REPLY = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] FRM_MAX = '1;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   frm_q, frm_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic [TOUT_W-1:0]  tmr_q, tmr_d;
   logic               last_data_q, last_data_d;
   logic               ovf_q, ovf_d;
   logic               fdr_q, fdr_d;

   logic [CNT_W-1:0]   need;
   logic [CNT_W-1:0]   frm_inc;
   logic               cnt_ok;
   logic               tmo;
   logic               dreq;

   // A zero flush threshold would fire with nothing queued, so the flush also needs frames.
   assign need    = (adc_cnt == '0) ? CNT_W'(1) : adc_cnt;
   assign cnt_ok  = (frm_q >= need);
   assign tmo     = (tout_cyc != '0) && (frm_q != '0) && (tmr_q == tout_cyc - TOUT_W'(1));
   assign dreq    = cnt_ok | tmo;
   assign frm_inc = (frame_wr && (frm_q != FRM_MAX)) ? frm_q + CNT_W'(1) : frm_q;

   always_comb begin
      state_d     = state_q;
      frm_d       = frm_q;
      len_d       = len_q;
      tmr_d       = tmr_q;
      last_data_d = last_data_q;
      ovf_d       = ovf_q;
      fdr_d       = 1'b0;

      if (state_q != S_IDLE) begin
         frm_d = frm_inc;
         if (frame_wr && (frm_q == FRM_MAX)) ovf_d = 1'b1;
      end

      // Timer holds at the flush point so a lost arbitration retries on the next WAIT cycle.
      if (frm_q == '0)
         tmr_d = '0;
      else if ((state_q == S_WAIT) && !tmo && (tmr_q != '1))
         tmr_d = tmr_q + TOUT_W'(1);

      case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (!enable) begin
               state_d = S_IDLE;
               frm_d   = '0;
               tmr_d   = '0;
            end else if (dreq && (!tx.fs_reply || !last_data_q)) begin
               state_d     = S_DATA;
               last_data_d = 1'b1;
               len_d       = (cnt_ok && (frm_q > need)) ? need : frm_q;
               frm_d       = frm_q - len_d + CNT_W'(frame_wr);
               tmr_d       = '0;
            end else if (tx.fs_reply) begin
               state_d     = S_REPLY;
               last_data_d = 1'b0;
            end
         end
         S_DATA, S_REPLY: begin
            if (tx.fd_udp_tx) begin
               state_d = S_DONE;
               fdr_d   = (state_q == S_REPLY);
            end
         end
         S_DONE: begin
            if (!tx.fd_udp_tx) begin
               len_d = '0;
               if (enable) begin
                  state_d = S_WAIT;
               end else begin
                  state_d = S_IDLE;
                  frm_d   = '0;
                  tmr_d   = '0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst_run) begin
         state_q     <= S_IDLE;
         frm_q       <= '0;
         len_q       <= '0;
         tmr_q       <= '0;
         last_data_q <= 1'b0;
         ovf_q       <= 1'b0;
         fdr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         frm_q       <= frm_d;
         len_q       <= len_d;
         tmr_q       <= tmr_d;
         last_data_q <= last_data_d;
         ovf_q       <= ovf_d;
         fdr_q       <= fdr_d;
      end
   end

   assign tx.fs_udp_tx = (state_q == S_DATA) || (state_q == S_REPLY);
   assign tx.tx_sel    = (state_q == S_REPLY);
   assign tx.tx_len    = len_q;
   assign tx.fd_reply  = fdr_q;
   assign frm_num      = frm_q;
   assign ovf          = ovf_q;
   assign sos          = {5'b0, state_q};

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed bench for eth_tx_sched: a cycle model of the scheduling rules checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_eth_tx_sched;

   logic        sys_clk = 1'b0;
   logic        rst_run;
   logic        enable;
   logic [7:0]  adc_cnt;
   logic [15:0] tout_cyc;
   logic        frame_wr;
   logic [7:0]  frm_num;
   logic        ovf;
   logic [7:0]  sos;

   eth_tx_sched_if #(.CNT_W(8)) tx_if ();

   eth_tx_sched #(.CNT_W(8), .TOUT_W(16)) dut (
      .sys_clk  (sys_clk),
      .rst_run  (rst_run),
      .enable   (enable),
      .adc_cnt  (adc_cnt),
      .tout_cyc (tout_cyc),
      .frame_wr (frame_wr),
      .tx       (tx_if),
      .frm_num  (frm_num),
      .ovf      (ovf),
      .sos      (sos)
   );

   always #5 sys_clk = ~sys_clk;

   int nvec = 0;
   int nerr = 0;
   bit chk_en = 1'b0;
   int reply_pulses = 0;

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: phase follows the debug codes (0 idle,1 wait,2 data,3 reply,4 done).
   int m_st, m_frm, m_age, m_len;
   bit m_ovf, m_fdr, m_last_data;

   always @(posedge sys_clk) begin
      int need, nf, nst, nage, nlen;
      bit cnt_ok, tmo, nfdr;
      if (rst_run) begin
         m_st = 0; m_frm = 0; m_age = 0; m_len = 0;
         m_ovf = 0; m_fdr = 0; m_last_data = 0;
      end else begin
         need   = (adc_cnt == 0) ? 1 : int'(adc_cnt);
         cnt_ok = (m_frm >= need);
         tmo    = (tout_cyc != 0) && (m_frm != 0) && (m_age == int'(tout_cyc) - 1);
         nf = m_frm; nst = m_st; nage = m_age; nlen = m_len; nfdr = 0;
         if (m_st != 0 && frame_wr) begin
            if (m_frm == 255) m_ovf = 1;
            else nf = m_frm + 1;
         end
         if (m_frm == 0) nage = 0;
         else if (m_st == 1 && !tmo && m_age < 65535) nage = m_age + 1;
         if (m_st == 0) begin
            if (enable) nst = 1;
         end else if (m_st == 1) begin
            if (!enable) begin
               nst = 0; nf = 0; nage = 0;
            end else if ((cnt_ok || tmo) && !(tx_if.fs_reply && m_last_data)) begin
               nst = 2; m_last_data = 1; nage = 0;
               nlen = cnt_ok ? ((m_frm < need) ? m_frm : need) : m_frm;
               nf = m_frm - nlen + int'(frame_wr);
            end else if (tx_if.fs_reply) begin
               nst = 3; m_last_data = 0;
            end
         end else if (m_st == 2 || m_st == 3) begin
            if (tx_if.fd_udp_tx) begin
               nfdr = (m_st == 3);
               nst = 4;
            end
         end else if (m_st == 4) begin
            if (!tx_if.fd_udp_tx) begin
               nlen = 0;
               if (enable) nst = 1;
               else begin nst = 0; nf = 0; nage = 0; end
            end
         end
         m_st = nst; m_frm = nf; m_age = nage; m_len = nlen; m_fdr = nfdr;
      end
   end

   always @(negedge sys_clk) begin
      if (chk_en) begin
         chk("sos", int'(sos), m_st);
         chk("fs_udp_tx", int'(tx_if.fs_udp_tx), int'(m_st == 2 || m_st == 3));
         chk("tx_sel", int'(tx_if.tx_sel), int'(m_st == 3));
         chk("tx_len", int'(tx_if.tx_len), m_len);
         chk("frm_num", int'(frm_num), m_frm);
         chk("ovf", int'(ovf), int'(m_ovf));
         chk("fd_reply", int'(tx_if.fd_reply), int'(m_fdr));
      end
      if (tx_if.fd_reply === 1'b1) reply_pulses++;
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic wait_fs(input int maxc, output int n);
      n = 0;
      while (tx_if.fs_udp_tx !== 1'b1 && n < maxc) begin
         tick();
         n++;
      end
      if (tx_if.fs_udp_tx !== 1'b1) chk("fs_udp_tx timeout", 0, 1);
   endtask

   task automatic finish_tx();
      int n;
      n = 0;
      tx_if.fd_udp_tx = 1'b1;
      while (tx_if.fs_udp_tx === 1'b1 && n < 10) begin
         tick();
         n++;
      end
      if (tx_if.fs_udp_tx !== 1'b0) chk("fd handshake timeout", 1, 0);
      tx_if.fd_udp_tx = 1'b0;
      tick();
   endtask

   initial begin
      int n;
      int sel [4];
      rst_run = 1'b1; enable = 1'b0; adc_cnt = 8'd4; tout_cyc = 16'd0; frame_wr = 1'b0;
      tx_if.fs_reply = 1'b0; tx_if.fd_udp_tx = 1'b0;
      tick(); tick();
      chk_en = 1'b1;
      chk("reset sos", int'(sos), 0);
      chk("reset fs_udp_tx", int'(tx_if.fs_udp_tx), 0);
      chk("reset frm_num", int'(frm_num), 0);
      chk("reset ovf", int'(ovf), 0);

      rst_run = 1'b0; enable = 1'b1;
      tick();
      chk("idle->wait", int'(sos), 1);

      // Count-triggered data packet.
      frame_wr = 1'b1;
      repeat (4) tick();
      frame_wr = 1'b0;
      chk("t1 frm_num after 4", int'(frm_num), 4);
      chk("t1 no grant yet", int'(tx_if.fs_udp_tx), 0);
      tick();
      chk("t1 fs_udp_tx", int'(tx_if.fs_udp_tx), 1);
      chk("t1 tx_sel", int'(tx_if.tx_sel), 0);
      chk("t1 tx_len", int'(tx_if.tx_len), 4);
      chk("t1 frm_num at grant", int'(frm_num), 0);
      tx_if.fd_udp_tx = 1'b1;
      tick();
      chk("t1 done sos", int'(sos), 4);
      chk("t1 fs dropped", int'(tx_if.fs_udp_tx), 0);
      tx_if.fd_udp_tx = 1'b0;
      tick();
      chk("t1 back to wait", int'(sos), 1);
      chk("t1 tx_len cleared", int'(tx_if.tx_len), 0);

      // Timeout flush.
      tout_cyc = 16'd100;
      frame_wr = 1'b1;
      repeat (2) tick();
      frame_wr = 1'b0;
      wait_fs(200, n);
      chk("t2 flush latency", n, 99);
      chk("t2 tx_len", int'(tx_if.tx_len), 2);
      chk("t2 frm_num", int'(frm_num), 0);
      finish_tx();
      tout_cyc = 16'd0;

      // Round robin from reset with both requesters pending.
      rst_run = 1'b1; tick(); rst_run = 1'b0; tick();
      adc_cnt = 8'd20;
      frame_wr = 1'b1;
      repeat (8) tick();
      frame_wr = 1'b0;
      chk("t3 preload", int'(frm_num), 8);
      reply_pulses = 0;
      adc_cnt = 8'd2;
      tx_if.fs_reply = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_fs(20, n);
         sel[i] = int'(tx_if.tx_sel);
         if (sel[i] == 0) chk("t3 data tx_len", int'(tx_if.tx_len), 2);
         if (i == 3) begin
            adc_cnt = 8'd20;
            tx_if.fs_reply = 1'b0;
         end
         finish_tx();
      end
      chk("t3 grant0", sel[0], 0);
      chk("t3 grant1", sel[1], 1);
      chk("t3 grant2", sel[2], 0);
      chk("t3 grant3", sel[3], 1);
      chk("t3 fd_reply pulses", reply_pulses, 2);
      chk("t3 frames left", int'(frm_num), 4);

      // frame_wr coincident with a data grant.
      frame_wr = 1'b1;
      tick();
      chk("t4 frm_num 5", int'(frm_num), 5);
      adc_cnt = 8'd4;
      tick();
      frame_wr = 1'b0;
      chk("t4 granted", int'(tx_if.fs_udp_tx), 1);
      chk("t4 tx_len", int'(tx_if.tx_len), 4);
      chk("t4 frm_num", int'(frm_num), 2);
      finish_tx();

      // enable dropped mid-transaction.
      frame_wr = 1'b1;
      repeat (2) tick();
      frame_wr = 1'b0;
      wait_fs(5, n);
      enable = 1'b0;
      tick();
      chk("t5 still data", int'(sos), 2);
      tx_if.fd_udp_tx = 1'b1;
      tick();
      chk("t5 done", int'(sos), 4);
      tx_if.fd_udp_tx = 1'b0;
      tick();
      chk("t5 idle", int'(sos), 0);
      chk("t5 frm_num cleared", int'(frm_num), 0);
      frame_wr = 1'b1;
      repeat (3) tick();
      frame_wr = 1'b0;
      chk("t5 frames ignored", int'(frm_num), 0);

      // Saturation while the worker withholds done, then reset mid-data.
      enable = 1'b1; adc_cnt = 8'd255;
      tick();
      tx_if.fs_reply = 1'b1;
      tick();
      chk("t6 reply granted", int'(sos), 3);
      frame_wr = 1'b1;
      repeat (255) tick();
      chk("t6 saturated", int'(frm_num), 255);
      chk("t6 no ovf yet", int'(ovf), 0);
      tick();
      frame_wr = 1'b0;
      chk("t6 ovf", int'(ovf), 1);
      chk("t6 frm_num held", int'(frm_num), 255);
      tx_if.fd_udp_tx = 1'b1;
      tick();
      chk("t6 fd_reply", int'(tx_if.fd_reply), 1);
      tx_if.fs_reply = 1'b0;
      tx_if.fd_udp_tx = 1'b0;
      tick();
      tick();
      chk("t6 data grant", int'(sos), 2);
      chk("t6 tx_len 255", int'(tx_if.tx_len), 255);
      rst_run = 1'b1;
      tick();
      rst_run = 1'b0;
      chk("t6 rst fs_udp_tx", int'(tx_if.fs_udp_tx), 0);
      chk("t6 rst tx_len", int'(tx_if.tx_len), 0);
      chk("t6 rst ovf", int'(ovf), 0);
      chk("t6 rst sos", int'(sos), 0);

      // adc_cnt of zero behaves as one frame per packet.
      tick();
      adc_cnt = 8'd0;
      frame_wr = 1'b1;
      tick();
      frame_wr = 1'b0;
      tick();
      chk("adc0 granted", int'(tx_if.fs_udp_tx), 1);
      chk("adc0 tx_len", int'(tx_if.tx_len), 1);
      finish_tx();
      tick();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
